vga_scanout: RTL and testbench

- Reader side of the 160x120 3-bit pixel framebuffer that the game's drawing logic writes through its (x, y, colour, plot) port.
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock.
- Fetches each framebuffer pixel through a synchronous read port and replicates it 4x4 to fill the screen.
- Drives the board VGA DAC pins directly.
- Provides a one-clock frame-boundary pulse so game logic can synchronise redraws.

---
 rtl/vga_scanout.sv | 146 ++++++++++++++
 tb/tb_vga_scanout.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// Framebuffer scanout: 160x120 3-bit pixels replicated 4x4 onto 640x480@60 VGA.
// Pins lag the counters by two pixel ticks; rd_data is consumed one clock after rd_addr.
module vga_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clock,
    input  logic        resetn,
    output logic [14:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic        frame_start,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
    localparam logic [HW-1:0] H_SS    = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] H_SE    = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
    localparam logic [VW-1:0] V_PRE   = VW'(V_VIS - 1);
    localparam logic [VW-1:0] V_SS    = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] V_SE    = VW'(V_VIS + V_FP + V_SYNC);

    logic          r_toggle;
    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    logic [14:0]   r_rd_addr;
    logic          r_frame_start;
    logic          r_hs0;
    logic          r_vs0;
    logic          r_vis0;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank_n;
    logic [9:0]    r_red;
    logic [9:0]    r_grn;
    logic [9:0]    r_blu;

    logic          w_pix_en;
    logic          w_h_last;
    logic          w_vis;
    logic          w_hsync;
    logic          w_vsync;
    logic [14:0]   w_fx;
    logic [14:0]   w_fy;
    logic [14:0]   w_addr;

    assign w_pix_en = r_toggle;
    assign w_h_last = (r_hcount == H_LAST);
    assign w_vis    = (r_hcount < H_VIS_C) && (r_vcount < V_VIS_C);
    assign w_hsync  = (r_hcount >= H_SS) && (r_hcount < H_SE);
    assign w_vsync  = (r_vcount >= V_SS) && (r_vcount < V_SE);

    // y*160 as (y<<7)+(y<<5) keeps the address path multiplier-free
    assign w_fx   = 15'(r_hcount >> 2);
    assign w_fy   = 15'(r_vcount >> 2);
    assign w_addr = (w_fy << 7) + (w_fy << 5) + w_fx;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_toggle      <= 1'b0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_toggle      <= ~r_toggle;
            r_frame_start <= 1'b0;
            if (w_pix_en) begin
                r_frame_start <= w_h_last && (r_vcount == V_PRE);
                if (w_h_last) begin
                    r_hcount <= '0;
                    r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + VW'(1);
                end else begin
                    r_hcount <= r_hcount + HW'(1);
                end
            end
        end
    end

    // Stage 0: address and sync/blank flags for the current counter position
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rd_addr <= '0;
            r_hs0     <= 1'b1;
            r_vs0     <= 1'b1;
            r_vis0    <= 1'b0;
        end else if (w_pix_en) begin
            if (w_vis) begin
                r_rd_addr <= w_addr;
            end
            r_hs0  <= ~w_hsync;
            r_vs0  <= ~w_vsync;
            r_vis0 <= w_vis;
        end
    end

    // Stage 1: rd_data has been valid since the clock between the two ticks
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_red     <= '0;
            r_grn     <= '0;
            r_blu     <= '0;
        end else if (w_pix_en) begin
            r_hs      <= r_hs0;
            r_vs      <= r_vs0;
            r_blank_n <= r_vis0;
            r_red     <= {10{rd_data[2] & r_vis0}};
            r_grn     <= {10{rd_data[1] & r_vis0}};
            r_blu     <= {10{rd_data[0] & r_vis0}};
        end
    end

    assign rd_addr     = r_rd_addr;
    assign frame_start = r_frame_start;
    assign VGA_CLK     = r_toggle;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_R       = r_red;
    assign VGA_G       = r_grn;
    assign VGA_B       = r_blu;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout using a shrunken raster (48x19 total) so whole frames fit in a short run.
module tb_vga_scanout;

    localparam int HV = 32, HF = 4, HS = 8, HB = 4;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 48
    localparam int VT = VV + VF + VS + VB;   // 19
    localparam int FR = HT * VT;             // 912 ticks per frame

    logic        clock  = 1'b0;
    logic        resetn = 1'b1;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data = 3'b000;
    logic        frame_start;
    logic        vclk, hs, vs, blank_n, sync_n;
    logic [9:0]  red, grn, blu;
    logic        ram_all = 1'b0;

    vga_scanout #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clock(clock), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_start(frame_start), .VGA_CLK(vclk), .VGA_HS(hs), .VGA_VS(vs),
        .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n),
        .VGA_R(red), .VGA_G(grn), .VGA_B(blu)
    );

    always #10 clock = ~clock;

    // Synchronous-read RAM: data = addr[2:0], or all ones in blanking-test mode
    always @(posedge clock) rd_data <= ram_all ? 3'b111 : rd_addr[2:0];

    int checks = 0;
    int errors = 0;
    int mm_pins = 0, mm_addr = 0, mm_fs = 0, mm_clk = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [14:0] fb_addr(input int h, input int v);
        return 15'((v / 4) * 160 + h / 4);
    endfunction

    // Reference model: n = clocks since reset release, sampled just after the n-th rising edge
    task automatic score(input int n);
        int t, p, h, v;
        logic xhs, xvs, xbl, xfs;
        logic [2:0] xrgb;
        logic [14:0] pa, xa;
        t = n / 2;
        xhs = 1'b1; xvs = 1'b1; xbl = 1'b0; xrgb = 3'b000;
        if (t >= 2) begin
            p = (t - 2) % FR; h = p % HT; v = p / HT;
            xhs = !(h >= HV + HF && h < HV + HF + HS);
            xvs = !(v >= VV + VF && v < VV + VF + VS);
            xbl = (h < HV) && (v < VV);
            pa = fb_addr(h, v);
            xrgb = xbl ? (ram_all ? 3'b111 : pa[2:0]) : 3'b000;
        end
        xa = '0;
        if (t >= 1) begin
            p = (t - 1) % FR; h = p % HT; v = p / HT;
            if (v >= VV) begin h = HV - 1; v = VV - 1; end
            else if (h >= HV) h = HV - 1;
            xa = fb_addr(h, v);
        end
        xfs = (n % 2 == 0) && (t >= 1) && (t % FR == VV * HT);
        if (hs !== xhs || vs !== xvs || blank_n !== xbl || red !== {10{xrgb[2]}} ||
            grn !== {10{xrgb[1]}} || blu !== {10{xrgb[0]}}) mm_pins++;
        if (rd_addr !== xa) mm_addr++;
        if (frame_start !== xfs) mm_fs++;
        if (vclk !== n[0]) mm_clk++;
    endtask

    typedef struct {
        int          n;
        logic        clk;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [2:0]  rgb;
        logic [14:0] addr;
        logic        fs;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n, ti, lit, dark_bad;
        int hs_f1, hs_f2, hs_r1, vs_f1, vs_f2, vs_r1, fs1, fs2, fs_cnt, bl_r1;
        logic p_hs, p_vs, p_bl;

        tbl[0] = '{4,    1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 15'd0,   1'b0};
        tbl[1] = '{5,    1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 15'd0,   1'b0};
        tbl[2] = '{12,   1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 15'd1,   1'b0};
        tbl[3] = '{76,   1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 15'd7,   1'b0};
        tbl[4] = '{412,  1'b0, 1'b1, 1'b1, 1'b1, 3'b011, 15'd163, 1'b0};
        tbl[5] = '{500,  1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 15'd162, 1'b0};
        tbl[6] = '{1122, 1'b0, 1'b1, 1'b1, 1'b1, 3'b111, 15'd327, 1'b0};
        tbl[7] = '{1152, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 15'd327, 1'b1};
        tbl[8] = '{1153, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 15'd327, 1'b0};
        tbl[9] = '{1348, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 15'd327, 1'b0};

        // Reset held for 10 clocks
        #1 resetn = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_blank", blank_n, 0);
        check("rst_rgb", red | grn | blu, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_vclk", vclk, 0);
        check("rst_fs", frame_start, 0);
        check("sync_n", sync_n, 1);
        @(negedge clock) resetn = 1'b1;

        // Two full frames against the model, table probes and edge measurements
        n = 0; ti = 0; fs_cnt = 0;
        hs_f1 = -1; hs_f2 = -1; hs_r1 = -1; vs_f1 = -1; vs_f2 = -1; vs_r1 = -1;
        fs1 = -1; fs2 = -1; bl_r1 = -1;
        p_hs = hs; p_vs = vs; p_bl = blank_n;
        for (int k = 0; k < 2 * 2 * FR + 100; k++) begin
            @(posedge clock); #1; n++;
            score(n);
            if (ti < 10 && tbl[ti].n == n) begin
                check($sformatf("vec%0d_clk", ti), vclk, tbl[ti].clk);
                check($sformatf("vec%0d_hs", ti), hs, tbl[ti].hs);
                check($sformatf("vec%0d_vs", ti), vs, tbl[ti].vs);
                check($sformatf("vec%0d_blank", ti), blank_n, tbl[ti].bl);
                check($sformatf("vec%0d_r", ti), red, {10{tbl[ti].rgb[2]}});
                check($sformatf("vec%0d_g", ti), grn, {10{tbl[ti].rgb[1]}});
                check($sformatf("vec%0d_b", ti), blu, {10{tbl[ti].rgb[0]}});
                check($sformatf("vec%0d_addr", ti), rd_addr, tbl[ti].addr);
                check($sformatf("vec%0d_fs", ti), frame_start, tbl[ti].fs);
                ti++;
            end
            if (p_hs && !hs) begin if (hs_f1 < 0) hs_f1 = n; else if (hs_f2 < 0) hs_f2 = n; end
            if (!p_hs && hs && hs_r1 < 0) hs_r1 = n;
            if (p_vs && !vs) begin if (vs_f1 < 0) vs_f1 = n; else if (vs_f2 < 0) vs_f2 = n; end
            if (!p_vs && vs && vs_r1 < 0) vs_r1 = n;
            if (!p_bl && blank_n && bl_r1 < 0) bl_r1 = n;
            if (frame_start) begin
                fs_cnt++;
                if (fs1 < 0) fs1 = n; else if (fs2 < 0) fs2 = n;
            end
            p_hs = hs; p_vs = vs; p_bl = blank_n;
        end
        check("vec_count", ti, 10);
        check("blank_rise_clk", bl_r1, 4);
        check("hs_start_after_blank", hs_f1 - bl_r1, 2 * (HV + HF));
        check("hs_low_clks", hs_r1 - hs_f1, 2 * HS);
        check("line_period_clks", hs_f2 - hs_f1, 2 * HT);
        check("vs_first_fall_clk", vs_f1, 2 * ((VV + VF) * HT + 2));
        check("vs_low_clks", vs_r1 - vs_f1, 2 * VS * HT);
        check("frame_period_clks", vs_f2 - vs_f1, 2 * FR);
        check("fs_first_clk", fs1, 2 * VV * HT);
        check("fs_period_clks", fs2 - fs1, 2 * FR);
        check("fs_pulse_count", fs_cnt, 2);

        // Blanking with all-ones RAM, then reset in mid-frame at (20,5)
        resetn = 1'b0;
        ram_all = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock) resetn = 1'b1;
        n = 0; lit = 0; dark_bad = 0;
        while (n < 521) begin
            @(posedge clock); #1; n++;
            score(n);
            if (n % 2 == 0 && n / 2 >= 2 && n / 2 < 2 + HT &&
                red == 10'h3FF && grn == 10'h3FF && blu == 10'h3FF) lit++;
            if (!blank_n && (red | grn | blu) != 10'd0) dark_bad++;
        end
        check("lit_ticks_line0", lit, HV);
        check("colour_in_blank", dark_bad, 0);

        resetn = 1'b0;
        #1;
        check("mid_rst_hs", hs, 1);
        check("mid_rst_vs", vs, 1);
        check("mid_rst_blank", blank_n, 0);
        check("mid_rst_rgb", red | grn | blu, 0);
        check("mid_rst_addr", rd_addr, 0);
        check("mid_rst_vclk", vclk, 0);
        repeat (3) @(posedge clock);
        @(negedge clock) resetn = 1'b1;
        n = 0;
        while (hs && n < 400) begin
            @(posedge clock); #1; n++;
        end
        check("mid_rst_hs_fall_clks", n, 2 * (HV + HF + 2));

        check("model_pins", mm_pins, 0);
        check("model_addr", mm_addr, 0);
        check("model_frame_start", mm_fs, 0);
        check("model_vga_clk", mm_clk, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
